// File: rtl/t05_huffman_decoder.sv
// Huffman stream decoder: 32-bit symbol count header, then walks a binary tree held in an
// external SRAM one node fetch per level, emitting one character per leaf reached.
module t05_huffman_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  en_state,
    input  logic        bitIn,
    input  logic        bitValid,
    output logic        bitReady,
    input  logic [8:0]  rootAddr,
    output logic        nodeReq,
    output logic [8:0]  nodeAddr,
    input  logic        nodeAck,
    input  logic [18:0] nodeData,
    output logic [7:0]  charOut,
    output logic        charValid,
    output logic        err,
    output logic [3:0]  fin_state
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DEPTH_W = 8;
    localparam int unsigned HBIT_W  = 5;
    localparam int unsigned CHAR_W  = 8;
    localparam logic [3:0]  EN_ACTIVE = 4'd7;
    localparam logic [3:0]  FIN_DONE  = 4'd8;
    localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(128);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_BIT, S_EMIT, S_DONE, S_ERR
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    count, count_n;
    logic [CNT_W-1:0]    remaining, remaining_n;
    logic [DEPTH_W-1:0]  depth, depth_n;
    logic [ADDR_W-1:0]   cur, cur_n;
    logic [ADDR_W-1:0]   left, left_n;
    logic [ADDR_W-1:0]   right, right_n;
    logic [HBIT_W-1:0]   hdr_bits, hdr_bits_n;
    logic [CHAR_W-1:0]   char_q, char_n;
    logic                err_q, err_n;

    logic                active;
    logic                ready_c, req_c, valid_c;
    logic [3:0]          fin_c;
    logic [CNT_W-1:0]    shifted;
    logic [CNT_W-1:0]    rem_dec;
    logic [DEPTH_W-1:0]  depth_inc;

    assign active    = (en_state == EN_ACTIVE);
    assign shifted   = {count[CNT_W-2:0], bitIn};
    assign rem_dec   = remaining - CNT_W'(1);
    assign depth_inc = depth + DEPTH_W'(1);

    // Next-state and handshake decode; every register holds unless the active state moves it.
    always_comb begin
        state_n     = state;
        count_n     = count;
        remaining_n = remaining;
        depth_n     = depth;
        cur_n       = cur;
        left_n      = left;
        right_n     = right;
        hdr_bits_n  = hdr_bits;
        char_n      = char_q;
        err_n       = err_q;
        ready_c     = 1'b0;
        req_c       = 1'b0;
        valid_c     = 1'b0;
        fin_c       = 4'd0;

        case (state)
            S_IDLE: begin
                if (active) begin
                    state_n    = S_HDR;
                    hdr_bits_n = '0;
                    count_n    = '0;
                end
            end
            S_HDR: begin
                if (active) begin
                    ready_c = 1'b1;
                    if (bitValid) begin
                        count_n    = shifted;
                        hdr_bits_n = hdr_bits + HBIT_W'(1);
                        if (hdr_bits == HBIT_W'(31)) begin
                            if (shifted == '0) begin
                                state_n = S_DONE;
                            end else begin
                                remaining_n = shifted;
                                cur_n       = rootAddr;
                                depth_n     = '0;
                                state_n     = S_FETCH;
                            end
                        end
                    end
                end
            end
            S_FETCH: begin
                // Acks seen while frozen are dropped; the request simply reissues on resume.
                if (active) begin
                    req_c = 1'b1;
                    if (nodeAck) begin
                        if (nodeData[18]) begin
                            char_n  = nodeData[7:0];
                            state_n = S_EMIT;
                        end else begin
                            left_n  = nodeData[17:9];
                            right_n = nodeData[8:0];
                            state_n = S_BIT;
                        end
                    end
                end
            end
            S_BIT: begin
                if (active) begin
                    ready_c = 1'b1;
                    if (bitValid) begin
                        cur_n   = bitIn ? right : left;
                        depth_n = depth_inc;
                        if (depth_inc == DEPTH_LIMIT) begin
                            state_n = S_ERR;
                            err_n   = 1'b1;
                        end else begin
                            state_n = S_FETCH;
                        end
                    end
                end
            end
            S_EMIT: begin
                if (active) begin
                    valid_c     = 1'b1;
                    remaining_n = rem_dec;
                    if (rem_dec == '0) begin
                        state_n = S_DONE;
                    end else begin
                        cur_n   = rootAddr;
                        depth_n = '0;
                        state_n = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (active) begin
                    fin_c = FIN_DONE;
                end else begin
                    state_n = S_IDLE;
                    char_n  = '0;
                end
            end
            S_ERR: begin
                fin_c = FIN_DONE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            remaining <= '0;
            depth     <= '0;
            cur       <= '0;
            left      <= '0;
            right     <= '0;
            hdr_bits  <= '0;
            char_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            remaining <= remaining_n;
            depth     <= depth_n;
            cur       <= cur_n;
            left      <= left_n;
            right     <= right_n;
            hdr_bits  <= hdr_bits_n;
            char_q    <= char_n;
            err_q     <= err_n;
        end
    end

    assign bitReady  = ready_c;
    assign nodeReq   = req_c;
    assign nodeAddr  = (state == S_FETCH) ? cur : '0;
    assign charOut   = char_q;
    assign charValid = valid_c;
    assign err       = err_q;
    assign fin_state = fin_c;

endmodule

// File: doc/t05_huffman_decoder.md
T05_HUFFMAN_DECODER -- requirements
Module: t05_huffman_decoder

Interface
REQ-001 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-002 SHALL expose ports, in order (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en_state  in  4  system state; block active only when en_state == 7
- bitIn  in  1  next compressed-stream bit
- bitValid  in  1  bitIn valid this cycle
- bitReady  out  1  block accepts bitIn this cycle
- rootAddr  in  9  tree-SRAM address of root node
- nodeReq  out  1  tree read request
- nodeAddr  out  9  tree read address
- nodeAck  in  1  nodeData valid this cycle
- nodeData  in  19  node word
- charOut  out  8  decoded character
- charValid  out  1  one-cycle pulse, charOut valid
- err  out  1  sticky depth-overflow flag
- fin_state  out  4  8 when decode complete, else 0

REQ-003 SHALL interpret nodeData as follows:
- [18]=1 marks a leaf, with [7:0] = character.
- [18]=0 marks an internal node, with [17:9] = left child (bit 0) and [8:0] = right child (bit 1).

Function
REQ-004 SHALL implement FSM states IDLE, HDR, FETCH, BIT, EMIT, DONE, ERR.
REQ-005 IDLE: all outputs 0; when en_state==7, go to HDR next cycle with bit counter=0 and count=0.
REQ-006 HDR:
- bitReady=1.
- Each handshake (bitValid&bitReady) shifts bitIn into the 32-bit count register, MSB first.
- After the 32nd bit: if count==0, go to DONE; otherwise set remaining=count, cur=rootAddr, depth=0, and go to FETCH.
REQ-007 FETCH:
- nodeReq=1 and nodeAddr=cur, held stable until nodeAck.
- In the ack cycle: a leaf latches charOut=nodeData[7:0] and goes to EMIT; an internal node latches both children and goes to BIT.
REQ-008 BIT:
- bitReady=1.
- On handshake, cur = bitIn ? right : left and depth increments.
- If depth becomes 128, go to ERR; otherwise go to FETCH.
REQ-009 EMIT:
- charValid=1 for exactly one cycle and remaining decrements.
- If remaining becomes 0, go to DONE; otherwise set cur=rootAddr, depth=0, and go to FETCH.
REQ-010 A root that is itself a leaf (single-symbol file) SHALL emit count characters while consuming no bits after the header.
REQ-011 DONE: fin_state=8 while en_state==7; when en_state!=7, return to IDLE with fin_state=0.
REQ-012 ERR: err=1 (sticky until rst), fin_state=8, bitReady=0, nodeReq=0; stays in ERR until rst.
REQ-013 The decoder SHALL consume exactly 32 header bits plus the code bits per character, with no sentinel bit, matching the stream the team's encoder writes.
REQ-014 When en_state!=7 outside IDLE/DONE:
- All registers SHALL hold.
- bitReady, nodeReq and charValid SHALL be 0.
- Operation SHALL resume in the same state when en_state returns to 7.
- An ack arriving while frozen SHALL be ignored; the request is reissued on resume.
REQ-015 bitReady and nodeReq SHALL never be 1 in the same cycle; at most one bit is consumed per cycle.
REQ-016 The remaining counter SHALL be 32-bit unsigned, depth 7-bit plus overflow detection; no wrap is permitted.
REQ-017 Latency:
- Header: 32 accepted bits, then FETCH the following cycle.
- Each tree level: 1 FETCH cycle plus ack wait, plus 1 BIT cycle minimum.
- EMIT: 1 cycle.

Reset
REQ-018 On rst:
- state=IDLE.
- count, remaining, depth, cur = 0.
- charOut=0, charValid=0, bitReady=0, nodeReq=0, nodeAddr=0, err=0, fin_state=0.
REQ-019 rst asserted mid-decode SHALL abort in the same edge, with no further charValid pulse.

Verification
REQ-020 Header only: en_state=7, stream 32 zero bits -> DONE; fin_state=8; no charValid; nodeReq never asserted.
REQ-021 Two-symbol tree:
- Tree: root@0 {left=1 leaf 'A', right=2 leaf 'B'}, zero-wait ack.
- Stream: count=3, bits 0,1,0.
- Response: charOut A, B, A on three charValid pulses, then fin_state=8.
REQ-022 Single-leaf root 'Z': count=4 -> four 'Z' pulses; bitReady=0 after the header.
REQ-023 Stalls: bitValid low at random and nodeAck delayed 0-5 cycles -> same output sequence as REQ-021; nodeAddr stable while nodeReq is high.
REQ-024 Freeze: drop en_state to 5 for 10 cycles mid-BIT -> no handshakes or pulses during the freeze; decode completes correctly after return to 7.
REQ-025 Degenerate tree: a chain of 128 internal nodes -> err=1 and fin_state=8 after the 128th bit; rst clears err.
